regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter_pkg.sv | 14 +
 rtl/regfile_wr_arbiter_if.sv | 25 ++
 rtl/regfile_wr_arbiter_rr_arbiter.sv | 28 ++
 rtl/regfile_wr_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and helpers for the register-file write arbiter.
package regfile_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } state_e;

  // Index width with a floor of one bit so single-entry configs still get a port.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side and register-file-side signals of the write arbiter.
interface regfile_wr_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int AW    = 1,
  parameter int WIDTH = 1
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][AW-1:0]    req_addr;
  logic [N_REQ-1:0][WIDTH-1:0] req_data;
  logic                        wen;
  logic [AW-1:0]               waddr;
  logic [WIDTH-1:0]            wdata;
  logic                        init_done;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wen, waddr, wdata, init_done
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wen, waddr, wdata, init_done
  );
endinterface

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int PW   = addr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req[i] && (i == (int'(ptr) + k) % N_REQ)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// N-requester round-robin write arbiter into a single register-file write port.
// Optional power-up clear sweep is enabled by defining REGFILE_ARB_INIT_EN.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter int               N_REG      = 1,
  parameter int               N_REQ      = 2,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic clk,
  input  logic rst_n,
  regfile_wr_arbiter_if.slave bus
);

  localparam int AW = addr_w(N_REG);
  localparam int PW = addr_w(N_REQ);

  logic [PW-1:0]    ptr, ptr_nxt;
  logic [N_REQ-1:0] grant;
  logic             accept;
  logic             wr_vld;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

`ifdef REGFILE_ARB_INIT_EN
  state_e        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == AW'(N_REG - 1)) begin
          state_nxt = ARB;
          cnt_nxt   = '0;
        end
      end
      ARB: ;
    endcase
  end

  assign accept        = rst_n && (state == ARB);
  assign bus.init_done = (state == ARB);
`else
  assign accept        = rst_n;
  assign bus.init_done = 1'b1;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Gating with rst_n keeps requesters from seeing a grant that reset will discard.
  assign bus.req_ready = accept ? grant : '0;

  always_comb begin
    wr_vld  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    ptr_nxt = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        wr_vld  = 1'b1;
        wr_addr = bus.req_addr[i];
        wr_data = bus.req_data[i];
        ptr_nxt = PW'((i + 1) % N_REQ);
      end
    end
`ifdef REGFILE_ARB_INIT_EN
    if (state == INIT) begin
      wr_vld  = 1'b1;
      wr_addr = cnt;
      wr_data = INIT_VALUE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.wen   <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
      ptr       <= '0;
    end else begin
      bus.wen <= wr_vld;
      ptr     <= ptr_nxt;
      if (wr_vld) begin
        bus.waddr <= wr_addr;
        bus.wdata <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench: 3-requester arbiter (N_REG=4) plus a single-requester instance (N_REG=3).
module tb_regfile_wr_arbiter;
  import regfile_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.N_REQ(3), .AW(2), .WIDTH(8)) b0 ();
  regfile_wr_arbiter_if #(.N_REQ(1), .AW(2), .WIDTH(8)) b1 ();

  regfile_wr_arbiter #(.WIDTH(8), .N_REG(4), .N_REQ(3), .INIT_VALUE(8'hA5)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));
  regfile_wr_arbiter #(.WIDTH(8), .N_REG(3), .N_REQ(1), .INIT_VALUE(8'h3C)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]      valid;
    logic [2:0][1:0] addr;
    logic [2:0][7:0] data;
    logic [2:0]      exp_ready;
    logic            exp_wen;
    logic [1:0]      exp_waddr;
    logic [7:0]      exp_wdata;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic apply(input string nm, input logic [2:0] v, input logic [2:0][1:0] a,
                       input logic [2:0][7:0] d, input logic [2:0] er, input logic ew,
                       input logic [1:0] ea, input logic [7:0] ed);
    b0.req_valid = v;
    b0.req_addr  = a;
    b0.req_data  = d;
    #1;
    chk({nm, " ready"}, 32'(b0.req_ready), 32'(er));
    @(posedge clk); #1;
    chk({nm, " wen"}, 32'(b0.wen), 32'(ew));
    chk({nm, " waddr"}, 32'(b0.waddr), 32'(ea));
    chk({nm, " wdata"}, 32'(b0.wdata), 32'(ed));
  endtask

  task automatic release_and_init();
    rst_n = 1'b1;
`ifdef REGFILE_ARB_INIT_EN
    repeat (4) @(posedge clk);
    #1;
`endif
    chk("init_done after release", 32'(b0.init_done), 32'd1);
  endtask

  initial begin
    // ptr starts at 0; rows run back-to-back so each depends on the previous ptr.
    tbl[0]  = '{3'b111, {2'd2, 2'd1, 2'd0}, {8'hC2, 8'hB1, 8'hA0}, 3'b001, 1'b1, 2'd0, 8'hA0};
    tbl[1]  = '{3'b111, {2'd2, 2'd1, 2'd0}, {8'hC2, 8'hB1, 8'hA0}, 3'b010, 1'b1, 2'd1, 8'hB1};
    tbl[2]  = '{3'b111, {2'd2, 2'd1, 2'd0}, {8'hC2, 8'hB1, 8'hA0}, 3'b100, 1'b1, 2'd2, 8'hC2};
    tbl[3]  = '{3'b111, {2'd2, 2'd1, 2'd0}, {8'hC2, 8'hB1, 8'hA0}, 3'b001, 1'b1, 2'd0, 8'hA0};
    tbl[4]  = '{3'b111, {2'd2, 2'd1, 2'd0}, {8'hC2, 8'hB1, 8'hA0}, 3'b010, 1'b1, 2'd1, 8'hB1};
    tbl[5]  = '{3'b111, {2'd2, 2'd1, 2'd0}, {8'hC2, 8'hB1, 8'hA0}, 3'b100, 1'b1, 2'd2, 8'hC2};
    tbl[6]  = '{3'b000, {2'd0, 2'd0, 2'd0}, {8'h00, 8'h00, 8'h00}, 3'b000, 1'b0, 2'd2, 8'hC2};
    tbl[7]  = '{3'b100, {2'd3, 2'd0, 2'd0}, {8'h5C, 8'h00, 8'h00}, 3'b100, 1'b1, 2'd3, 8'h5C};
    tbl[8]  = '{3'b011, {2'd0, 2'd1, 2'd1}, {8'h00, 8'h22, 8'h11}, 3'b001, 1'b1, 2'd1, 8'h11};
    tbl[9]  = '{3'b010, {2'd0, 2'd1, 2'd1}, {8'h00, 8'h22, 8'h11}, 3'b010, 1'b1, 2'd1, 8'h22};
    tbl[10] = '{3'b011, {2'd0, 2'd1, 2'd0}, {8'h00, 8'h22, 8'h33}, 3'b001, 1'b1, 2'd0, 8'h33};
    tbl[11] = '{3'b101, {2'd2, 2'd0, 2'd0}, {8'h44, 8'h00, 8'h33}, 3'b100, 1'b1, 2'd2, 8'h44};
    tbl[12] = '{3'b110, {2'd2, 2'd3, 2'd0}, {8'h44, 8'h55, 8'h00}, 3'b010, 1'b1, 2'd3, 8'h55};

    b0.req_valid = '0; b0.req_addr = '0; b0.req_data = '0;
    b1.req_valid = '0; b1.req_addr = '0; b1.req_data = '0;

    // Reset state, with requests driven to show ready is suppressed.
    repeat (2) @(posedge clk);
    #1;
    b0.req_valid = 3'b111;
    b1.req_valid = 1'b1;
    #1;
    chk("rst ready0", 32'(b0.req_ready), 32'd0);
    chk("rst ready1", 32'(b1.req_ready), 32'd0);
    chk("rst wen", 32'(b0.wen), 32'd0);
    chk("rst waddr", 32'(b0.waddr), 32'd0);
    chk("rst wdata", 32'(b0.wdata), 32'd0);
    chk("rst wen1", 32'(b1.wen), 32'd0);
`ifdef REGFILE_ARB_INIT_EN
    chk("rst init_done", 32'(b0.init_done), 32'd0);
`else
    chk("rst init_done", 32'(b0.init_done), 32'd1);
`endif
    b0.req_valid = '0;
    b1.req_valid = '0;
    rst_n = 1'b1;

`ifdef REGFILE_ARB_INIT_EN
    b0.req_valid = 3'b111;
    #1;
    chk("init ready", 32'(b0.req_ready), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk("init wen", 32'(b0.wen), 32'd1);
      chk("init waddr", 32'(b0.waddr), 32'(k - 1));
      chk("init wdata", 32'(b0.wdata), 32'hA5);
      chk("init init_done", 32'(b0.init_done), (k == 4) ? 32'd1 : 32'd0);
      if (k < 4) chk("init ready busy", 32'(b0.req_ready), 32'd0);
    end
    b0.req_valid = '0;
`else
    @(posedge clk); #1;
    chk("post-rst wen", 32'(b0.wen), 32'd0);
`endif

    for (int r = 0; r < 13; r++)
      apply($sformatf("row%0d", r), tbl[r].valid, tbl[r].addr, tbl[r].data,
            tbl[r].exp_ready, tbl[r].exp_wen, tbl[r].exp_waddr, tbl[r].exp_wdata);

    // Five idle cycles: nothing granted, outputs hold, pointer (2) preserved.
    for (int c = 0; c < 5; c++)
      apply("idle", 3'b000, '0, '0, 3'b000, 1'b0, 2'd3, 8'h55);
    apply("ptr held", 3'b111, {2'd1, 2'd2, 2'd3}, {8'h66, 8'h77, 8'h88}, 3'b100, 1'b1, 2'd1, 8'h66);
    apply("ptr to 1", 3'b001, {2'd0, 2'd0, 2'd2}, {8'h00, 8'h00, 8'h12}, 3'b001, 1'b1, 2'd2, 8'h12);

    // Reset landing on an accepted request drops the write and clears ptr.
    b0.req_valid = 3'b101;
    b0.req_addr  = {2'd3, 2'd0, 2'd1};
    b0.req_data  = {8'hEE, 8'h00, 8'hDD};
    rst_n = 1'b0;
    #1;
    chk("midrst ready", 32'(b0.req_ready), 32'd0);
    @(posedge clk); #1;
    chk("midrst wen", 32'(b0.wen), 32'd0);
    chk("midrst waddr", 32'(b0.waddr), 32'd0);
    chk("midrst wdata", 32'(b0.wdata), 32'd0);
    b0.req_valid = '0;
    release_and_init();
    apply("ptr cleared", 3'b101, {2'd3, 2'd0, 2'd1}, {8'hEE, 8'h00, 8'hDD}, 3'b001, 1'b1, 2'd1, 8'hDD);
    b0.req_valid = '0;

    // Single requester always granted; out-of-range address forwarded unchanged.
    b1.req_valid = 1'b1;
    b1.req_addr  = {2'd3};
    b1.req_data  = {8'h7E};
    #1;
    chk("n1 ready a", 32'(b1.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("n1 wen a", 32'(b1.wen), 32'd1);
    chk("n1 waddr a", 32'(b1.waddr), 32'd3);
    chk("n1 wdata a", 32'(b1.wdata), 32'h7E);
    b1.req_data = {8'h81};
    #1;
    chk("n1 ready b", 32'(b1.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("n1 wen b", 32'(b1.wen), 32'd1);
    chk("n1 wdata b", 32'(b1.wdata), 32'h81);
    b1.req_valid = 1'b0;
    #1;
    chk("n1 ready idle", 32'(b1.req_ready), 32'd0);
    @(posedge clk); #1;
    chk("n1 wen idle", 32'(b1.wen), 32'd0);

`ifdef REGFILE_ARB_INIT_EN
    // Reset while the sweep counter sits at 2, then the sweep restarts from 0.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("sweep abort pre waddr", 32'(b0.waddr), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("sweep abort wen", 32'(b0.wen), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("sweep restart wen", 32'(b0.wen), 32'd1);
    chk("sweep restart waddr", 32'(b0.waddr), 32'd0);
    chk("sweep restart init_done", 32'(b0.init_done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("sweep restart done", 32'(b0.init_done), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
